lock_input_ctrl: RTL and testbench

Front-end controller that drives the password-lock FSM's command side from raw board switches and push-buttons. It synchronizes and debounces the enter and change buttons and latches the switch code onto `userpass`. It issues single-cycle `enter`/`change` commands, then samples the lock's `OPEN`/`NEW`/`ALARM` response into a status code. It sits between the board I/O pins and the lock FSM, and owns all command sequencing toward it.

---
 rtl/lock_input_ctrl_if.sv | 25 ++
 rtl/lock_input_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lock_input_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lock_input_ctrl_if.sv
// Board and lock-facing signals of the lock input controller.
// The master side is the controller; the slave side is the board pins plus the lock FSM.
interface lock_input_ctrl_if;
    logic [3:0] sw;
    logic       btn_enter_n;
    logic       btn_change_n;
    logic       OPEN;
    logic       NEW;
    logic       ALARM;
    logic [3:0] userpass;
    logic       enter;
    logic       change;
    logic       busy;
    logic [1:0] status;

    modport master (
        input  sw, btn_enter_n, btn_change_n, OPEN, NEW, ALARM,
        output userpass, enter, change, busy, status
    );

    modport slave (
        output sw, btn_enter_n, btn_change_n, OPEN, NEW, ALARM,
        input  userpass, enter, change, busy, status
    );
endinterface

// File: rtl/lock_input_ctrl.sv
// Debounces the enter/change buttons, issues one-cycle commands to the lock FSM
// and folds the lock's OPEN/NEW/ALARM response into a 2-bit status code.
module lock_input_ctrl #(
    parameter int DB_CYCLES   = 16,
    parameter int DB_W        = 5,
    parameter int RESP_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    lock_input_ctrl_if.master bus
);

    localparam int WAIT_W = (RESP_CYCLES > 1) ? $clog2(RESP_CYCLES) : 1;

    localparam logic [1:0] ST_NONE   = 2'b00;
    localparam logic [1:0] ST_ACCEPT = 2'b01;
    localparam logic [1:0] ST_REJECT = 2'b10;
    localparam logic [1:0] ST_ALARM  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        REPORT  = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    // Bit 0 is the enter button, bit 1 the change button.
    logic [1:0] btn_raw;
    logic [1:0] press_evt;

    assign btn_raw = {bus.btn_change_n, bus.btn_enter_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic            db_d_reg;
            logic            press_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    db_reg    <= 1'b1;
                    db_d_reg  <= 1'b1;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    // Any cycle of agreement restarts the run; only an unbroken run commits.
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_W'(DB_CYCLES - 1)) begin
                        db_reg  <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    db_d_reg  <= db_reg;
                    press_reg <= db_d_reg & ~db_reg;
                end
            end

            assign press_evt[gi] = press_reg;
        end
    endgenerate

    state_t            state_reg,    state_next;
    logic              op_reg,       op_next;      // 0 = enter, 1 = change
    logic [3:0]        userpass_reg, userpass_next;
    logic [1:0]        status_reg,   status_next;
    logic [WAIT_W-1:0] wait_reg,     wait_next;
    logic              enter_cmd;
    logic              change_cmd;
    logic              busy_flag;
    logic              resp_ok;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg    <= IDLE;
            op_reg       <= 1'b0;
            userpass_reg <= 4'b0000;
            status_reg   <= ST_NONE;
            wait_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            userpass_reg <= userpass_next;
            status_reg   <= status_next;
            wait_reg     <= wait_next;
        end
    end

    assign resp_ok = op_reg ? bus.NEW : bus.OPEN;

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        userpass_next = userpass_reg;
        status_next   = status_reg;
        wait_next     = wait_reg;
        enter_cmd     = 1'b0;
        change_cmd    = 1'b0;
        busy_flag     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.ALARM) begin
                    status_next = ST_ALARM;
                    state_next  = LOCKOUT;
                end else if (press_evt[0]) begin
                    userpass_next = bus.sw;
                    op_next       = 1'b0;
                    state_next    = ISSUE;
                end else if (press_evt[1]) begin
                    userpass_next = bus.sw;
                    op_next       = 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                enter_cmd   = ~op_reg;
                change_cmd  = op_reg;
                busy_flag   = 1'b1;
                status_next = ST_NONE;
                wait_next   = WAIT_W'(RESP_CYCLES - 1);
                state_next  = WAIT;
            end
            WAIT: begin
                busy_flag = 1'b1;
                if (wait_reg == '0) begin
                    state_next = REPORT;
                end else begin
                    wait_next = wait_reg - 1'b1;
                end
            end
            REPORT: begin
                if (bus.ALARM) begin
                    status_next = ST_ALARM;
                    state_next  = LOCKOUT;
                end else begin
                    status_next = resp_ok ? ST_ACCEPT : ST_REJECT;
                    state_next  = IDLE;
                end
            end
            LOCKOUT: begin
                status_next = ST_ALARM;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.userpass = userpass_reg;
    assign bus.enter    = enter_cmd;
    assign bus.change   = change_cmd;
    assign bus.busy     = busy_flag;
    assign bus.status   = status_reg;

endmodule

// File: tb/tb_lock_input_ctrl.sv
// Directed bench for lock_input_ctrl with DB_CYCLES=4, RESP_CYCLES=2; the bench
// plays both the board (switches, buttons) and the lock (OPEN/NEW/ALARM).
module tb_lock_input_ctrl;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    int   enter_cnt;
    int   change_cnt;
    int   e0;
    int   c0;

    lock_input_ctrl_if bus ();

    lock_input_ctrl #(
        .DB_CYCLES  (4),
        .DB_W       (5),
        .RESP_CYCLES(2)
    ) dut (
        .Clock (clk),
        .Resetn(rstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        enter_cnt  = 0;
        change_cnt = 0;
    end

    always @(negedge clk) begin
        if (bus.enter)  enter_cnt  = enter_cnt + 1;
        if (bus.change) change_cnt = change_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] pass %s: value %0h", tag, got);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn             = 1'b0;
        bus.sw           = 4'b0000;
        bus.btn_enter_n  = 1'b1;
        bus.btn_change_n = 1'b1;
        bus.OPEN         = 1'b0;
        bus.NEW          = 1'b0;
        bus.ALARM        = 1'b0;

        #3;
        check("rst_userpass", 32'(bus.userpass), 32'h0);
        check("rst_enter",    32'(bus.enter),    32'h0);
        check("rst_change",   32'(bus.change),   32'h0);
        check("rst_busy",     32'(bus.busy),     32'h0);
        check("rst_status",   32'(bus.status),   32'h0);
        tick(2);
        rstn = 1'b1;
        tick(2);

        // Correct code: button first sampled low at edge 1, ISSUE at edge 8.
        e0 = enter_cnt;
        bus.sw = 4'b0110;
        bus.OPEN = 1'b1;
        bus.btn_enter_n = 1'b0;
        tick(7);
        check("ok_enter_e7", 32'(bus.enter), 32'h0);
        check("ok_busy_e7",  32'(bus.busy),  32'h0);
        tick(1);
        check("ok_enter_e8",    32'(bus.enter),    32'h1);
        check("ok_busy_e8",     32'(bus.busy),     32'h1);
        check("ok_userpass_e8", 32'(bus.userpass), 32'h6);
        tick(1);
        check("ok_enter_e9", 32'(bus.enter), 32'h0);
        check("ok_busy_e9",  32'(bus.busy),  32'h1);
        tick(2);
        check("ok_busy_e11", 32'(bus.busy), 32'h0);
        tick(1);
        check("ok_status_e12", 32'(bus.status), 32'h1);
        tick(8);
        bus.btn_enter_n = 1'b1;
        tick(12);
        check("ok_pulses",   32'(enter_cnt - e0), 32'h1);
        check("ok_userpass", 32'(bus.userpass),   32'h6);

        // Bounce: 2-cycle toggles never reach the debounce threshold.
        e0 = enter_cnt;
        c0 = change_cnt;
        for (int i = 0; i < 3; i++) begin
            bus.btn_enter_n = 1'b0;
            tick(2);
            bus.btn_enter_n = 1'b1;
            tick(2);
        end
        tick(12);
        check("bounce_enter",  32'(enter_cnt - e0),  32'h0);
        check("bounce_change", 32'(change_cnt - c0), 32'h0);
        check("bounce_status", 32'(bus.status),      32'h1);

        // Simultaneous presses: enter wins, change dropped.
        e0 = enter_cnt;
        c0 = change_cnt;
        bus.sw = 4'b1010;
        bus.NEW = 1'b1;
        bus.btn_enter_n  = 1'b0;
        bus.btn_change_n = 1'b0;
        tick(20);
        bus.btn_enter_n  = 1'b1;
        bus.btn_change_n = 1'b1;
        tick(12);
        check("both_enter",    32'(enter_cnt - e0),  32'h1);
        check("both_change",   32'(change_cnt - c0), 32'h0);
        check("both_userpass", 32'(bus.userpass),    32'ha);
        check("both_status",   32'(bus.status),      32'h1);

        // Change pressed one cycle after enter: its event lands in ISSUE and is lost.
        e0 = enter_cnt;
        c0 = change_cnt;
        bus.sw = 4'b0011;
        bus.btn_enter_n = 1'b0;
        tick(1);
        bus.btn_change_n = 1'b0;
        tick(25);
        bus.btn_enter_n  = 1'b1;
        bus.btn_change_n = 1'b1;
        tick(12);
        check("busy_enter",    32'(enter_cnt - e0),  32'h1);
        check("busy_change",   32'(change_cnt - c0), 32'h0);
        check("busy_userpass", 32'(bus.userpass),    32'h3);

        // Alarm: wrong code rejected, then lock raises ALARM during second attempt.
        e0 = enter_cnt;
        c0 = change_cnt;
        bus.OPEN = 1'b0;
        bus.NEW  = 1'b0;
        bus.sw   = 4'b0001;
        bus.btn_enter_n = 1'b0;
        tick(12);
        check("alarm_status1", 32'(bus.status), 32'h2);
        bus.btn_enter_n = 1'b1;
        tick(10);
        bus.btn_enter_n = 1'b0;
        tick(9);
        bus.ALARM = 1'b1;
        tick(3);
        check("alarm_status2", 32'(bus.status), 32'h3);
        check("alarm_busy",    32'(bus.busy),   32'h0);
        bus.btn_enter_n = 1'b1;
        bus.ALARM = 1'b0;
        tick(10);
        check("alarm_cmds", 32'(enter_cnt - e0), 32'h2);
        e0 = enter_cnt;
        c0 = change_cnt;
        bus.OPEN = 1'b1;
        bus.btn_enter_n = 1'b0;
        tick(15);
        bus.btn_enter_n = 1'b1;
        tick(10);
        bus.btn_change_n = 1'b0;
        tick(15);
        bus.btn_change_n = 1'b1;
        tick(10);
        check("lock_enter",  32'(enter_cnt - e0),  32'h0);
        check("lock_change", 32'(change_cnt - c0), 32'h0);
        check("lock_status", 32'(bus.status),      32'h3);
        check("lock_busy",   32'(bus.busy),        32'h0);

        // Reset clears lockout.
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(2);
        check("unlock_status", 32'(bus.status), 32'h0);

        // Mid-command asynchronous reset.
        bus.sw = 4'b1111;
        bus.btn_enter_n = 1'b0;
        tick(9);
        check("mid_busy",     32'(bus.busy),     32'h1);
        check("mid_userpass", 32'(bus.userpass), 32'hf);
        bus.btn_enter_n = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check("arst_userpass", 32'(bus.userpass), 32'h0);
        check("arst_status",   32'(bus.status),   32'h0);
        check("arst_busy",     32'(bus.busy),     32'h0);
        check("arst_enter",    32'(bus.enter),    32'h0);
        tick(3);
        rstn = 1'b1;
        e0 = enter_cnt;
        c0 = change_cnt;
        tick(20);
        check("post_rst_enter",  32'(enter_cnt - e0),  32'h0);
        check("post_rst_change", 32'(change_cnt - c0), 32'h0);
        check("post_rst_status", 32'(bus.status),      32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
